uart_rx_fifo: RTL
=================

UART_RX_FIFO -- requirements
Module: uart_rx_fifo

Interface
REQ-001 SHALL have parameter CLKS_PER_BIT, default 104, clocks per serial bit (>=4).
REQ-002 SHALL have parameter DEPTH_LOG2, default 4, FIFO depth 2**DEPTH_LOG2 bytes.
REQ-003 SHALL have port clk  input  1  sole clock, all state on rising edge.
REQ-004 SHALL have port reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port rx  input  1  asynchronous serial line, 8N1, idle high.
REQ-006 SHALL have port rd  input  1  pop strobe, one cycle per byte consumed (CPU uart0_rd).
REQ-007 SHALL have port valid  output  1  FIFO non-empty (CPU uart0_valid).
REQ-008 SHALL have port data  output  8  head-of-FIFO byte, meaningful only while valid (CPU uart0_data).
REQ-009 SHALL have port overrun  output  1  one-cycle pulse: received byte dropped, FIFO full.
REQ-010 SHALL have port frame_err  output  1  one-cycle pulse: stop bit sampled low.
REQ-011 SHALL have port level  output  DEPTH_LOG2+1  current FIFO occupancy.

Function
REQ-012 SHALL pass rx through a two-flop synchronizer; each flop resets to 1.
REQ-013 SHALL implement FSM states IDLE, START, DATA, STOP, BREAK.
REQ-014 IDLE: on synchronized rx going low, SHALL load bit counter with CLKS_PER_BIT/2 and enter START.
REQ-015 START: at counter expiry, SHALL sample rx; if high (glitch) return to IDLE with no output; if low enter DATA with counter reloaded to CLKS_PER_BIT.
REQ-016 DATA: SHALL sample every CLKS_PER_BIT cycles, 8 bits, LSB first, shifted into an 8-bit register; after bit 7 enter STOP.
REQ-017 STOP: after CLKS_PER_BIT cycles SHALL sample rx; if high push byte and return to IDLE; if low pulse frame_err, discard byte, enter BREAK.
REQ-018 BREAK: SHALL remain until synchronized rx is high, then enter IDLE.
REQ-019 Push SHALL occur in the cycle following the stop-bit sample; valid SHALL be high the cycle after the push.
REQ-020 FIFO SHALL be show-ahead: data equals oldest unread byte whenever valid=1, without any rd.
REQ-021 rd with valid=1 SHALL pop; next byte (if any) appears on data the following cycle; level decrements.
REQ-022 rd with valid=0 SHALL be ignored; no state change, no pointer wrap.
REQ-023 Push while level=DEPTH and no pop in same cycle SHALL drop the byte and pulse overrun; stored contents unchanged.
REQ-024 Simultaneous push and pop SHALL both take effect: level unchanged, no overrun, even when full.
REQ-025 Read/write pointers SHALL be DEPTH_LOG2 bits wrapping modulo DEPTH; level SHALL be tracked with one extra bit to distinguish full from empty.
REQ-026 Bytes SHALL be delivered in arrival order, without loss, duplication or reordering, while level < DEPTH.

Reset
REQ-027 reset SHALL force FSM to IDLE, pointers and level to 0, shift register to 0, synchronizer flops to 1.
REQ-028 During and the cycle after reset: valid=0, overrun=0, frame_err=0, level=0; data=0.
REQ-029 reset mid-frame SHALL abandon the partial byte; if rx is still low after reset, no frame starts until rx returns high and then falls.
REQ-030 FIFO storage array contents need not reset; only pointers define validity.

Structure
REQ-031 UART constants (data bits 8, FSM state encoding) SHALL live in a shared package also used by the TX block.
REQ-032 The FIFO SHALL be a separate sub-module, sync_fifo, parameterised by width and DEPTH_LOG2, reusable for TX buffering.
REQ-033 The deserializer FSM and synchronizer SHALL remain in uart_rx_fifo; no other sub-modules.

Verification (CLKS_PER_BIT=4, DEPTH_LOG2=2)
REQ-034 Send 0x55 with correct framing, no rd -> valid rises 1 cycle after push, data=0x55, level=1, no error pulses.
REQ-035 Send 0x41,0x42,0x43 back-to-back, then rd three cycles apart -> data sequence 0x41,0x42,0x43, valid falls after third pop, level 0.
REQ-036 Send 5 bytes 0x01..0x05 with no rd -> level=4, overrun pulses once on the fifth byte, data=0x01 and contents 0x01..0x04 retained.
REQ-037 Fill to 4, assert rd in the exact push cycle of a fifth byte 0x99 -> no overrun, level stays 4, 0x99 read last.
REQ-038 Send 0xA5 with stop bit low, hold rx low 20 cycles -> frame_err pulses once, no push, no new frame until rx high then a new start bit.
REQ-039 rx low pulse of 1 cycle; separately, reset asserted mid-DATA of 0x3C -> no byte pushed in either case, valid=0, FIFO continues correctly on next valid frame.

Source files
------------

// File: rtl/uart_rx_fifo_pkg.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo_pkg
// Description : Shared UART constants and deserializer state encoding (RX/TX)
// Revision    : 1.0 - initial release
// ============================================================================
package uart_rx_fifo_pkg;

    localparam int c_data_bits = 8;
    localparam int c_bit_w     = $clog2(c_data_bits);

    typedef enum logic [2:0] {
        ST_IDLE  = 3'd0,
        ST_START = 3'd1,
        ST_DATA  = 3'd2,
        ST_STOP  = 3'd3,
        ST_BREAK = 3'd4
    } uart_state_t;

endpackage : uart_rx_fifo_pkg
`default_nettype wire

// File: rtl/sync_fifo.sv
`default_nettype none
// ============================================================================
// Module      : sync_fifo
// Description : Show-ahead synchronous FIFO with overrun pulse
// Revision    : 1.0 - initial release
// ============================================================================
module sync_fifo #(
    parameter int WIDTH      = 8,
    parameter int DEPTH_LOG2 = 4
) (
    input  logic                  clk,
    input  logic                  reset,
    input  logic                  i_wr_en,
    input  logic [WIDTH-1:0]      i_wr_data,
    input  logic                  i_rd_en,
    output logic                  o_valid,
    output logic [WIDTH-1:0]      o_rd_data,
    output logic                  o_overrun,
    output logic [DEPTH_LOG2:0]   o_level
);

    localparam int                    c_depth     = 1 << DEPTH_LOG2;
    localparam logic [DEPTH_LOG2:0]   c_level_max = {1'b1, {DEPTH_LOG2{1'b0}}};
    localparam logic [DEPTH_LOG2:0]   c_level_one = (DEPTH_LOG2+1)'(1);
    localparam logic [DEPTH_LOG2-1:0] c_ptr_one   = DEPTH_LOG2'(1);

    logic [WIDTH-1:0]      r_mem [c_depth];
    logic [DEPTH_LOG2-1:0] r_wr_ptr;
    logic [DEPTH_LOG2-1:0] r_rd_ptr;
    logic [DEPTH_LOG2:0]   r_level;
    logic                  r_overrun;

    logic w_empty;
    logic w_full;
    logic w_pop;
    logic w_push;

    assign w_empty = (r_level == '0);
    assign w_full  = (r_level == c_level_max);
    // A pop frees a slot in the same cycle, so a push into a full FIFO is legal then.
    assign w_pop   = i_rd_en & ~w_empty;
    assign w_push  = i_wr_en & (~w_full | w_pop);

    always_ff @(posedge clk) begin
        if (w_push) begin
            r_mem[r_wr_ptr] <= i_wr_data;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_wr_ptr  <= '0;
            r_rd_ptr  <= '0;
            r_level   <= '0;
            r_overrun <= 1'b0;
        end else begin
            r_overrun <= i_wr_en & w_full & ~w_pop;
            if (w_push) begin
                r_wr_ptr <= r_wr_ptr + c_ptr_one;
            end
            if (w_pop) begin
                r_rd_ptr <= r_rd_ptr + c_ptr_one;
            end
            case ({w_push, w_pop})
                2'b10:   r_level <= r_level + c_level_one;
                2'b01:   r_level <= r_level - c_level_one;
                default: r_level <= r_level;
            endcase
        end
    end

    assign o_valid   = ~w_empty;
    assign o_rd_data = w_empty ? '0 : r_mem[r_rd_ptr];
    assign o_overrun = r_overrun;
    assign o_level   = r_level;

endmodule : sync_fifo
`default_nettype wire

// File: rtl/uart_rx_fifo.sv
`default_nettype none
// ============================================================================
// Module      : uart_rx_fifo
// Description : 8N1 UART receiver feeding a show-ahead byte FIFO
// Revision    : 1.0 - initial release
// ============================================================================
module uart_rx_fifo
    import uart_rx_fifo_pkg::*;
#(
    parameter int CLKS_PER_BIT = 104,
    parameter int DEPTH_LOG2   = 4
) (
    input  logic                   clk,
    input  logic                   reset,
    input  logic                   rx,
    input  logic                   rd,
    output logic                   valid,
    output logic [c_data_bits-1:0] data,
    output logic                   overrun,
    output logic                   frame_err,
    output logic [DEPTH_LOG2:0]    level
);

    localparam int                 c_cnt_w    = $clog2(CLKS_PER_BIT + 1);
    localparam logic [c_cnt_w-1:0] c_cnt_full = c_cnt_w'(CLKS_PER_BIT);
    localparam logic [c_cnt_w-1:0] c_cnt_half = c_cnt_w'(CLKS_PER_BIT / 2);
    localparam logic [c_cnt_w-1:0] c_cnt_one  = c_cnt_w'(1);
    localparam logic [c_bit_w-1:0] c_bit_last = c_bit_w'(c_data_bits - 1);
    localparam logic [c_bit_w-1:0] c_bit_one  = c_bit_w'(1);

    logic                   r_sync1;
    logic                   r_sync2;
    logic [1:0]             r_fill;
    logic                   r_armed;
    uart_state_t            r_state;
    logic [c_cnt_w-1:0]     r_cnt;
    logic [c_bit_w-1:0]     r_bit_idx;
    logic [c_data_bits-1:0] r_shift;
    logic                   r_push;
    logic                   r_frame_err;

    uart_state_t            w_state_nxt;
    logic [c_cnt_w-1:0]     w_cnt_nxt;
    logic [c_bit_w-1:0]     w_bit_nxt;
    logic [c_data_bits-1:0] w_shift_nxt;
    logic                   w_push_nxt;
    logic                   w_fe_nxt;
    logic                   w_rx;
    logic                   w_tick;

    assign w_rx   = r_sync2;
    assign w_tick = (r_cnt == c_cnt_one);

    // Receiver is armed only once the line has been seen high after reset,
    // so a line held low across reset cannot masquerade as a start bit.
    always_ff @(posedge clk) begin
        if (reset) begin
            r_sync1 <= 1'b1;
            r_sync2 <= 1'b1;
            r_fill  <= '0;
            r_armed <= 1'b0;
        end else begin
            r_sync1 <= rx;
            r_sync2 <= r_sync1;
            r_fill  <= {r_fill[0], 1'b1};
            r_armed <= r_armed | (r_fill[1] & r_sync2);
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state     <= ST_IDLE;
            r_cnt       <= '0;
            r_bit_idx   <= '0;
            r_shift     <= '0;
            r_push      <= 1'b0;
            r_frame_err <= 1'b0;
        end else begin
            r_state     <= w_state_nxt;
            r_cnt       <= w_cnt_nxt;
            r_bit_idx   <= w_bit_nxt;
            r_shift     <= w_shift_nxt;
            r_push      <= w_push_nxt;
            r_frame_err <= w_fe_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_cnt_nxt   = r_cnt;
        w_bit_nxt   = r_bit_idx;
        w_shift_nxt = r_shift;
        w_push_nxt  = 1'b0;
        w_fe_nxt    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (r_armed && !w_rx) begin
                    w_state_nxt = ST_START;
                    w_cnt_nxt   = c_cnt_half;
                end
            end
            ST_START: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (w_rx) begin
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_state_nxt = ST_DATA;
                    w_cnt_nxt   = c_cnt_full;
                    w_bit_nxt   = '0;
                end
            end
            ST_DATA: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else begin
                    w_shift_nxt = {w_rx, r_shift[c_data_bits-1:1]};
                    w_cnt_nxt   = c_cnt_full;
                    if (r_bit_idx == c_bit_last) begin
                        w_state_nxt = ST_STOP;
                    end else begin
                        w_bit_nxt = r_bit_idx + c_bit_one;
                    end
                end
            end
            ST_STOP: begin
                if (!w_tick) begin
                    w_cnt_nxt = r_cnt - c_cnt_one;
                end else if (w_rx) begin
                    w_push_nxt  = 1'b1;
                    w_state_nxt = ST_IDLE;
                end else begin
                    w_fe_nxt    = 1'b1;
                    w_state_nxt = ST_BREAK;
                end
            end
            ST_BREAK: begin
                if (w_rx) begin
                    w_state_nxt = ST_IDLE;
                end
            end
            default: begin
                w_state_nxt = ST_IDLE;
            end
        endcase
    end

    sync_fifo #(
        .WIDTH      (c_data_bits),
        .DEPTH_LOG2 (DEPTH_LOG2)
    ) u_fifo (
        .clk       (clk),
        .reset     (reset),
        .i_wr_en   (r_push),
        .i_wr_data (r_shift),
        .i_rd_en   (rd),
        .o_valid   (valid),
        .o_rd_data (data),
        .o_overrun (overrun),
        .o_level   (level)
    );

    assign frame_err = r_frame_err;

endmodule : uart_rx_fifo
`default_nettype wire
